hamming_secded_channel: RTL and testbench

- Parametrised, pipelined SECDED channel: encode DATA_W-bit word, XOR an error-injection mask, decode, correct, report status.
- Successor to the fixed 4-bit combinational demo path; adds valid/ready handshake, optional Gray-coded input, arbitrary data width and saturating error counters.
- Sits between switch/Gray front end and LED/7-seg display mux.

---
 rtl/hamming_secded_channel.sv | 182 ++++++++++++++++++
 tb/tb_hamming_secded_channel.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_channel.sv
`timescale 1ns/1ps
// hamming_secded_channel
// Two-stage SECDED channel. A DATA_W-bit word (optionally Gray-coded) is
// Hamming-encoded with an extra overall-parity bit at position 0. The
// injection mask is XORed into the codeword, which is then decoded,
// corrected and classified. A valid/ready handshake runs on both sides,
// and saturating counters tally the delivered single and double errors.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   in_valid/in_ready      input handshake
//   in_data, in_gray       data word; in_gray=1 means in_data is Gray-coded
//   inj_mask               codeword bits to flip, sampled with in_data
//   out_valid/out_ready    output handshake
//   out_data               corrected data (raw extracted data on double error)
//   out_cw, out_syn        received codeword and its Hamming syndrome
//   out_status             00 clean, 01 single corrected, 10 uncorrectable
//   cnt_clr                synchronous clear of both counters
//   cnt_single/cnt_double  delivered words with status 01 / 10
module hamming_secded_channel #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 8,
    // Smallest R with 2^R >= DATA_W+R+1, tabulated for DATA_W in 2..32.
    localparam int R      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
    localparam int CW_W   = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_gray,
    input  logic [CW_W-1:0]   inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW_W-1:0]   out_cw,
    output logic [R-1:0]      out_syn,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    // CW_W fits in R+1 bits, so the out-of-range syndrome test is exact.
    localparam logic [R:0] CW_LIM = (R+1)'(CW_W);

    // Non-power-of-two positions (from 3 upward) carry data.
    function automatic logic is_data_pos(input int pos);
        return (pos & (pos - 1)) != 0;
    endfunction

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [DATA_W-1:0] gray_to_bin(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        for (int i = 0; i < DATA_W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic            p;
        int              k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (is_data_pos(pos)) begin
                cw[pos] = d[k];
                k++;
            end
        end
        // Parity slots are still zero here, so they drop out of their own XOR.
        for (int j = 0; j < R; j++) begin
            p = 1'b0;
            for (int pos = 1; pos < CW_W; pos++) begin
                if (((pos >> j) & 1) != 0) p = p ^ cw[pos];
            end
            cw[1 << j] = p;
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic logic [R-1:0] syndrome(input logic [CW_W-1:0] cw);
        logic [R-1:0] s;
        s = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (cw[pos]) s = s ^ pos[R-1:0];
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (is_data_pos(pos)) begin
                d[k] = cw[pos];
                k++;
            end
        end
        return d;
    endfunction

    logic              s1_valid;
    logic [CW_W-1:0]   s1_cw;
    logic              s2_valid;
    logic              s2_load;
    logic [R-1:0]      syn_c;
    logic              ov_c;
    logic [CW_W-1:0]   fixed_cw;
    logic [1:0]        status_c;
    logic [DATA_W-1:0] data_c;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = rst_n && (!s1_valid || s2_load);
    assign out_valid = s2_valid;

    // Decode the stage-1 codeword. Only a syndrome that points inside the
    // codeword and has odd overall parity is a correctable data or check-bit
    // error. A zero syndrome with odd parity means bit 0 itself flipped.
    always_comb begin
        syn_c    = syndrome(s1_cw);
        ov_c     = ^s1_cw;
        fixed_cw = s1_cw;
        status_c = 2'b00;
        if (syn_c == '0) begin
            status_c = ov_c ? 2'b01 : 2'b00;
        end else if (!ov_c || ({1'b0, syn_c} >= CW_LIM)) begin
            status_c = 2'b10;
        end else begin
            status_c = 2'b01;
            fixed_cw = s1_cw ^ (CW_W'(1) << syn_c);
        end
        data_c = extract(fixed_cw);
    end

    // Two-register pipeline. Stage 2 holds its contents while stalled, and
    // stage 1 can refill in the same cycle that it hands off to stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_cw      <= '0;
            s2_valid   <= 1'b0;
            out_data   <= '0;
            out_cw     <= '0;
            out_syn    <= '0;
            out_status <= 2'b00;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cw <= encode(in_gray ? gray_to_bin(in_data) : in_data) ^ inj_mask;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data   <= data_c;
                    out_cw     <= s1_cw;
                    out_syn    <= syn_c;
                    out_status <= status_c;
                end
            end
        end
    end

    // Words are counted only when delivered. A clear wins over a delivery
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_valid && out_ready) begin
            if (out_status == 2'b01 && cnt_single != '1) cnt_single <= cnt_single + CNT_W'(1);
            if (out_status == 2'b10 && cnt_double != '1) cnt_double <= cnt_double + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_channel.sv
`timescale 1ns/1ps
// Testbench for hamming_secded_channel. Three instances share the handshake
// and counter controls:
//   dut   DATA_W=4, CNT_W=8
//   dut_b DATA_W=4, CNT_W=2 (saturation)
//   dut_c DATA_W=8 (13-bit codeword)
// Expected values are computed by hand from the codeword layout.
module tb_hamming_secded_channel;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_gray;
    logic        out_ready;
    logic        cnt_clr;
    logic [3:0]  in_data;
    logic [7:0]  inj_mask;
    logic [7:0]  in_data_c;
    logic [12:0] inj_mask_c;

    logic        in_ready, out_valid;
    logic [3:0]  out_data;
    logic [7:0]  out_cw;
    logic [2:0]  out_syn;
    logic [1:0]  out_status;
    logic [7:0]  cnt_single, cnt_double;

    logic        in_ready_b, out_valid_b;
    logic [3:0]  out_data_b;
    logic [7:0]  out_cw_b;
    logic [2:0]  out_syn_b;
    logic [1:0]  out_status_b;
    logic [1:0]  cnt_single_b, cnt_double_b;

    logic        in_ready_c, out_valid_c;
    logic [7:0]  out_data_c;
    logic [12:0] out_cw_c;
    logic [3:0]  out_syn_c;
    logic [1:0]  out_status_c;
    logic [7:0]  cnt_single_c, cnt_double_c;

    int errors;
    int checks;

    hamming_secded_channel #(.DATA_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_gray(in_gray), .inj_mask(inj_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cw(out_cw), .out_syn(out_syn), .out_status(out_status),
        .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double)
    );

    hamming_secded_channel #(.DATA_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_gray(in_gray), .inj_mask(inj_mask),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_cw(out_cw_b), .out_syn(out_syn_b), .out_status(out_status_b),
        .cnt_clr(cnt_clr), .cnt_single(cnt_single_b), .cnt_double(cnt_double_b)
    );

    hamming_secded_channel #(.DATA_W(8), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data_c), .in_gray(in_gray), .inj_mask(inj_mask_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .out_cw(out_cw_c), .out_syn(out_syn_c), .out_status(out_status_c),
        .cnt_clr(cnt_clr), .cnt_single(cnt_single_c), .cnt_double(cnt_double_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one word for a single cycle, then waits (bounded) for out_valid.
    // Returns at the negedge where out_valid is first seen, with lat = cycles
    // since the word was presented, or -1 on timeout.
    task automatic send_word(input logic [3:0] d, input logic g, input logic [7:0] m,
                             output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_gray   = g;
        inj_mask  = m;
        out_ready = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_data, out_cw, out_syn, out_status} !== 17'h0) begin errors++;
            $display("[TB] FAIL reset_outputs got data=%h cw=%h syn=%h st=%b exp all 0", out_data, out_cw, out_syn, out_status); end
        checks++; if ({cnt_single, cnt_double} !== 16'h0) begin errors++;
            $display("[TB] FAIL reset_counters got single=%0d double=%0d exp 0", cnt_single, cnt_double); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_clean;
        int lat;
        send_word(4'hA, 1'b0, 8'h00, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL clean_latency got=%0d exp=2", lat); end
        checks++; if (out_cw !== 8'hA5) begin errors++; $display("[TB] FAIL clean_cw got=%h exp=a5", out_cw); end
        checks++; if (out_syn !== 3'd0) begin errors++; $display("[TB] FAIL clean_syn got=%0d exp=0", out_syn); end
        checks++; if (out_status !== 2'b00) begin errors++; $display("[TB] FAIL clean_status got=%b exp=00", out_status); end
        checks++; if (out_data !== 4'hA) begin errors++; $display("[TB] FAIL clean_data got=%h exp=a", out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_single;
        int lat;
        // Gray 0xF decodes to binary 0xA; bit 5 flipped.
        send_word(4'hF, 1'b1, 8'h20, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL single_latency got=%0d exp=2", lat); end
        checks++; if (out_cw !== 8'h85) begin errors++; $display("[TB] FAIL single_cw got=%h exp=85", out_cw); end
        checks++; if (out_syn !== 3'd5) begin errors++; $display("[TB] FAIL single_syn got=%0d exp=5", out_syn); end
        checks++; if (out_status !== 2'b01) begin errors++; $display("[TB] FAIL single_status got=%b exp=01", out_status); end
        checks++; if (out_data !== 4'hA) begin errors++; $display("[TB] FAIL single_data got=%h exp=a", out_data); end
        @(negedge clk);
        checks++; if (cnt_single !== 8'd1) begin errors++; $display("[TB] FAIL single_count got=%0d exp=1", cnt_single); end
    endtask

    task automatic test_double;
        int lat;
        send_word(4'hA, 1'b0, 8'h28, lat);
        checks++; if (out_syn !== 3'd6) begin errors++; $display("[TB] FAIL double_syn got=%0d exp=6", out_syn); end
        checks++; if (out_status !== 2'b10) begin errors++; $display("[TB] FAIL double_status got=%b exp=10", out_status); end
        checks++; if (out_data !== 4'h9) begin errors++; $display("[TB] FAIL double_raw_data got=%h exp=9", out_data); end
        @(negedge clk);
        checks++; if (cnt_double !== 8'd1) begin errors++; $display("[TB] FAIL double_count got=%0d exp=1", cnt_double); end
        // Only the overall parity bit flipped.
        send_word(4'hA, 1'b0, 8'h01, lat);
        checks++; if (out_cw !== 8'hA4) begin errors++; $display("[TB] FAIL ovbit_cw got=%h exp=a4", out_cw); end
        checks++; if (out_syn !== 3'd0) begin errors++; $display("[TB] FAIL ovbit_syn got=%0d exp=0", out_syn); end
        checks++; if (out_status !== 2'b01) begin errors++; $display("[TB] FAIL ovbit_status got=%b exp=01", out_status); end
        checks++; if (out_data !== 4'hA) begin errors++; $display("[TB] FAIL ovbit_data got=%h exp=a", out_data); end
        @(negedge clk);
        checks++; if (cnt_single !== 8'd2) begin errors++; $display("[TB] FAIL ovbit_count got=%0d exp=2", cnt_single); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_q[$];
        logic [3:0] held_data;
        logic [7:0] held_cw;
        logic       stalled_prev;
        logic       saw_low;
        int         next_word;
        int         accepted;
        int         delivered;
        stalled_prev = 1'b0;
        saw_low      = 1'b0;
        held_data    = '0;
        held_cw      = '0;
        next_word    = 1;
        accepted     = 0;
        delivered    = 0;
        in_gray      = 1'b0;
        inj_mask     = 8'h00;
        for (int cyc = 0; cyc < 40 && delivered < 6; cyc++) begin
            @(negedge clk);
            in_valid  = (next_word <= 6);
            in_data   = next_word[3:0];
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (stalled_prev) begin
                checks++;
                if (out_data !== held_data || out_cw !== held_cw) begin errors++;
                    $display("[TB] FAIL stall_hold got data=%h cw=%h exp data=%h cw=%h", out_data, out_cw, held_data, held_cw); end
            end
            if (!in_ready) begin
                saw_low = 1'b1;
                checks++;
                if (accepted - delivered !== 2) begin errors++;
                    $display("[TB] FAIL stall_occupancy got=%0d exp=2", accepted - delivered); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++;
                    $display("[TB] FAIL b2b_extra got data=%h exp no word", out_data);
                end else begin
                    if (out_data !== exp_q[0] || out_status !== 2'b00) begin errors++;
                        $display("[TB] FAIL b2b_order got data=%h st=%b exp data=%h st=00", out_data, out_status, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                accepted++;
                next_word++;
            end
            stalled_prev = out_valid && !out_ready;
            held_data    = out_data;
            held_cw      = out_cw;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (delivered !== 6) begin errors++; $display("[TB] FAIL b2b_delivered got=%0d exp=6", delivered); end
        checks++; if (saw_low !== 1'b1) begin errors++; $display("[TB] FAIL b2b_backpressure got=%b exp=1", saw_low); end
    endtask

    task automatic test_saturation;
        logic [7:0] masks [5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h40};
        int lat;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++; if (cnt_single !== 8'd0 || cnt_single_b !== 2'd0) begin errors++;
            $display("[TB] FAIL clear_counts got a=%0d b=%0d exp 0", cnt_single, cnt_single_b); end
        for (int i = 0; i < 5; i++) begin
            send_word(4'h5, 1'b0, masks[i], lat);
            checks++;
            if (out_status !== 2'b01 || out_data !== 4'h5) begin errors++;
                $display("[TB] FAIL sat_word%0d got st=%b data=%h exp st=01 data=5", i, out_status, out_data); end
        end
        @(negedge clk);
        checks++; if (cnt_single_b !== 2'd3) begin errors++; $display("[TB] FAIL sat_cnt2 got=%0d exp=3", cnt_single_b); end
        checks++; if (cnt_single !== 8'd5) begin errors++; $display("[TB] FAIL sat_cnt8 got=%0d exp=5", cnt_single); end
        send_word(4'h5, 1'b0, 8'h02, lat);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_delivered got=%b exp=0", out_valid); end
        checks++; if (cnt_single !== 8'd0 || cnt_single_b !== 2'd0) begin errors++;
            $display("[TB] FAIL clr_priority got a=%0d b=%0d exp 0", cnt_single, cnt_single_b); end
    endtask

    task automatic test_wide;
        int lat;
        in_data_c  = 8'hB5;
        inj_mask_c = 13'h0114;
        send_word(4'h0, 1'b0, 8'h00, lat);
        checks++; if (out_valid_c !== 1'b1) begin errors++; $display("[TB] FAIL wide_valid got=%b exp=1", out_valid_c); end
        checks++; if (out_syn_c !== 4'd14) begin errors++; $display("[TB] FAIL wide_syn got=%0d exp=14", out_syn_c); end
        checks++; if (out_status_c !== 2'b10) begin errors++; $display("[TB] FAIL wide_status got=%b exp=10", out_status_c); end
        checks++; if (out_data_c !== 8'hB5) begin errors++; $display("[TB] FAIL wide_raw_data got=%h exp=b5", out_data_c); end
        inj_mask_c = 13'h1000;
        send_word(4'h0, 1'b0, 8'h00, lat);
        checks++; if (out_syn_c !== 4'd12 || out_status_c !== 2'b01) begin errors++;
            $display("[TB] FAIL wide_single got syn=%0d st=%b exp syn=12 st=01", out_syn_c, out_status_c); end
        checks++; if (out_data_c !== 8'hB5) begin errors++; $display("[TB] FAIL wide_corrected got=%h exp=b5", out_data_c); end
        inj_mask_c = 13'h0000;
        @(negedge clk);
        checks++; if (cnt_double_c !== 8'd1) begin errors++; $display("[TB] FAIL wide_count got=%0d exp=1", cnt_double_c); end
    endtask

    task automatic test_reset_midflight;
        int stale;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 4'h3;
        inj_mask  = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = 4'h4;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL inflight_pre got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("[TB] FAIL midreset_valid got ov=%b ir=%b exp 0 0", out_valid, in_ready); end
        checks++; if (out_data !== 4'h0 || out_cw !== 8'h00) begin errors++;
            $display("[TB] FAIL midreset_data got data=%h cw=%h exp 0", out_data, out_cw); end
        checks++; if (cnt_double_c !== 8'd0 || cnt_single_c !== 8'd0) begin errors++;
            $display("[TB] FAIL midreset_counts got s=%0d d=%0d exp 0", cnt_single_c, cnt_double_c); end
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL stale_output got=%0d exp=0", stale); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_gray    = 1'b0;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        in_data    = 4'h0;
        inj_mask   = 8'h00;
        in_data_c  = 8'h00;
        inj_mask_c = 13'h0000;
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_back_to_back();
        test_saturation();
        test_wide();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
